// File: rtl/vga_pkg.sv
// Shared VGA definitions: standard timing sets and the pixel-word field layout.
package vga_pkg;

  typedef struct packed {
    int hsize;
    int hfp;
    int hsp;
    int hmax;
    int vsize;
    int vfp;
    int vsp;
    int vmax;
    bit hspp;
    bit vspp;
  } vga_timing_t;

  localparam vga_timing_t T_640X480_60 = '{
    hsize: 640, hfp: 656, hsp: 752, hmax: 800,
    vsize: 480, vfp: 490, vsp: 492, vmax: 525,
    hspp: 1'b0, vspp: 1'b0
  };

  localparam vga_timing_t T_800X600_72 = '{
    hsize: 800, hfp: 856, hsp: 976, hmax: 1040,
    vsize: 600, vfp: 637, vsp: 643, vmax: 666,
    hspp: 1'b1, vspp: 1'b1
  };

  // Pixel word is {8'x, R, G, B}
  localparam int PIX_R_LSB = 16;
  localparam int PIX_G_LSB = 8;
  localparam int PIX_B_LSB = 0;

endpackage

// File: rtl/vga_scanout_engine_if.sv
// Framebuffer read port: the engine issues address/strobe, memory returns data.
interface vga_scanout_engine_if #(
  parameter int ADDR_W = 19
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register that resets every stage to a chosen idle pattern.
module vga_delay_line #(
  parameter int             DEPTH   = 2,
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_stage [DEPTH];

  // NOTE: every stage is reset so the outputs show blanking, not stale pixels, right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_scanout_engine.sv
// VGA/DVI scan-out: timing counters, replicated framebuffer addressing,
// frame-boundary buffer swap and read-latency-aligned sync/enable/RGB.
module vga_scanout_engine
  import vga_pkg::*;
#(
  parameter int WIDTH      = 12,
  parameter int HSIZE      = T_800X600_72.hsize,
  parameter int HFP        = T_800X600_72.hfp,
  parameter int HSP        = T_800X600_72.hsp,
  parameter int HMAX       = T_800X600_72.hmax,
  parameter int VSIZE      = T_800X600_72.vsize,
  parameter int VFP        = T_800X600_72.vfp,
  parameter int VSP        = T_800X600_72.vsp,
  parameter int VMAX       = T_800X600_72.vmax,
  parameter int HSPP       = 1,
  parameter int VSPP       = 1,
  parameter int ADDR_W     = 19,
  parameter int SCALE_LOG2 = 0,
  parameter int RD_LAT     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_W-1:0]      base_a,
  input  logic [ADDR_W-1:0]      base_b,
  input  logic                   swap_req,
  output logic                   swap_ack,
  output logic                   buf_sel,
  vga_scanout_engine_if.master   fb,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   data_enable,
  output logic [7:0]             red,
  output logic [7:0]             green,
  output logic [7:0]             blue,
  output logic                   frame_start,
  output logic [WIDTH-1:0]       hdata,
  output logic [WIDTH-1:0]       vdata
);

  if (SCALE_LOG2 < 0 || SCALE_LOG2 > 3) begin : g_bad_scale
    $error("vga_scanout_engine: SCALE_LOG2 must be 0..3");
  end
  if ((HSIZE % (1 << SCALE_LOG2)) != 0) begin : g_bad_hsize
    $error("vga_scanout_engine: HSIZE must be divisible by 2**SCALE_LOG2");
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("vga_scanout_engine: RD_LAT must be 1..4");
  end

  localparam logic [WIDTH-1:0]  L_HSIZE = WIDTH'(HSIZE);
  localparam logic [WIDTH-1:0]  L_HFP   = WIDTH'(HFP);
  localparam logic [WIDTH-1:0]  L_HSP   = WIDTH'(HSP);
  localparam logic [WIDTH-1:0]  L_HEND  = WIDTH'(HMAX - 1);
  localparam logic [WIDTH-1:0]  L_VSIZE = WIDTH'(VSIZE);
  localparam logic [WIDTH-1:0]  L_VFP   = WIDTH'(VFP);
  localparam logic [WIDTH-1:0]  L_VSP   = WIDTH'(VSP);
  localparam logic [WIDTH-1:0]  L_VEND  = WIDTH'(VMAX - 1);
  localparam logic [WIDTH-1:0]  L_SMASK = WIDTH'((1 << SCALE_LOG2) - 1);
  localparam logic [ADDR_W-1:0] L_LSTEP = ADDR_W'(HSIZE >> SCALE_LOG2);
  localparam logic              L_HSPP  = (HSPP != 0);
  localparam logic              L_VSPP  = (VSPP != 0);
  localparam logic [3:0]        L_IDLE  = {~L_HSPP, ~L_VSPP, 2'b00};

  logic [WIDTH-1:0]  r_hdata, r_vdata;
  logic [ADDR_W-1:0] r_line_base, r_pix_off;
  logic              r_buf_sel, r_swap_ack, r_pend, r_base_vld;

  logic              w_line_end, w_frame_end, w_visible, w_do_swap, w_next_sel;
  logic              w_hs_raw, w_vs_raw, w_fs_raw;
  logic [ADDR_W-1:0] w_line_base, w_next_base;
  logic [3:0]        w_dl_q;
  logic              w_unused_pad;

  assign w_line_end  = (r_hdata == L_HEND);
  assign w_frame_end = w_line_end && (r_vdata == L_VEND);
  assign w_visible   = (r_hdata < L_HSIZE) && (r_vdata < L_VSIZE);
  assign w_do_swap   = w_frame_end && (r_pend || swap_req);
  assign w_next_sel  = r_buf_sel ^ w_do_swap;
  assign w_next_base = w_next_sel ? base_b : base_a;
  // Until the first clock after reset the line base has not been captured yet.
  assign w_line_base = r_base_vld ? r_line_base : base_a;

  assign w_hs_raw = ((r_hdata >= L_HFP) && (r_hdata < L_HSP)) ? L_HSPP : ~L_HSPP;
  assign w_vs_raw = ((r_vdata >= L_VFP) && (r_vdata < L_VSP)) ? L_VSPP : ~L_VSPP;
  assign w_fs_raw = (r_hdata == '0) && (r_vdata == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hdata     <= '0;
      r_vdata     <= '0;
      r_line_base <= '0;
      r_pix_off   <= '0;
      r_buf_sel   <= 1'b0;
      r_swap_ack  <= 1'b0;
      r_pend      <= 1'b0;
      r_base_vld  <= 1'b0;
    end else begin
      r_base_vld <= 1'b1;
      r_swap_ack <= w_do_swap;
      r_buf_sel  <= w_next_sel;
      r_pend     <= w_frame_end ? 1'b0 : (r_pend | swap_req);

      if (w_line_end) begin
        r_hdata   <= '0;
        r_pix_off <= '0;
        r_vdata   <= w_frame_end ? '0 : r_vdata + WIDTH'(1);
      end else begin
        r_hdata <= r_hdata + WIDTH'(1);
        if (w_visible && ((r_hdata & L_SMASK) == L_SMASK))
          r_pix_off <= r_pix_off + ADDR_W'(1);
      end

      // Each source row is repeated 2^S times, so step only after its last copy.
      if (w_frame_end)
        r_line_base <= w_next_base;
      else if (w_line_end && ((r_vdata & L_SMASK) == L_SMASK))
        r_line_base <= w_line_base + L_LSTEP;
      else
        r_line_base <= w_line_base;
    end
  end

  vga_delay_line #(
    .DEPTH   (RD_LAT),
    .W       (4),
    .RST_VAL (L_IDLE)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   ({w_hs_raw, w_vs_raw, w_visible, w_fs_raw}),
    .o_q   (w_dl_q)
  );

  // Counters sit at (0,0) during reset, so the strobe is held off by the reset pin itself.
  assign fb.rd_en   = w_visible && rst_n;
  assign fb.rd_addr = w_line_base + r_pix_off;

  assign hsync       = w_dl_q[3];
  assign vsync       = w_dl_q[2];
  assign data_enable = w_dl_q[1];
  assign frame_start = w_dl_q[0];

  assign red          = data_enable ? fb.rd_data[PIX_R_LSB +: 8] : 8'h00;
  assign green        = data_enable ? fb.rd_data[PIX_G_LSB +: 8] : 8'h00;
  assign blue         = data_enable ? fb.rd_data[PIX_B_LSB +: 8] : 8'h00;
  assign w_unused_pad = ^fb.rd_data[31:24];

  assign swap_ack = r_swap_ack;
  assign buf_sel  = r_buf_sel;
  assign hdata    = r_hdata;
  assign vdata    = r_vdata;

endmodule

// File: tb/tb_vga_scanout_engine.sv
// Directed bench for vga_scanout_engine on a 14x7 toy timing, scale 1x and 2x.
module tb_vga_scanout_engine;

  localparam int AW = 19;
  localparam int W  = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] base_a0 = 19'h100, base_b0 = 19'h200;
  logic [AW-1:0] base_a1 = 19'h000, base_b1 = 19'h000;
  logic          swap_req0 = 1'b0, swap_req1 = 1'b0;

  logic          swap_ack0, buf_sel0, hs0, vs0, de0, fs0;
  logic [7:0]    r0, g0, b0;
  logic [W-1:0]  hd0, vd0;
  logic          swap_ack1, buf_sel1, hs1, vs1, de1, fs1;
  logic [7:0]    r1, g1, b1;
  logic [W-1:0]  hd1, vd1;

  vga_scanout_engine_if #(.ADDR_W(AW)) fb0 ();
  vga_scanout_engine_if #(.ADDR_W(AW)) fb1 ();

  vga_scanout_engine #(
    .WIDTH(W), .HSIZE(8), .HFP(10), .HSP(12), .HMAX(14),
    .VSIZE(4), .VFP(5), .VSP(6), .VMAX(7), .HSPP(1), .VSPP(1),
    .ADDR_W(AW), .SCALE_LOG2(0), .RD_LAT(2)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .base_a(base_a0), .base_b(base_b0),
    .swap_req(swap_req0), .swap_ack(swap_ack0), .buf_sel(buf_sel0), .fb(fb0),
    .hsync(hs0), .vsync(vs0), .data_enable(de0), .red(r0), .green(g0), .blue(b0),
    .frame_start(fs0), .hdata(hd0), .vdata(vd0)
  );

  vga_scanout_engine #(
    .WIDTH(W), .HSIZE(8), .HFP(10), .HSP(12), .HMAX(14),
    .VSIZE(4), .VFP(5), .VSP(6), .VMAX(7), .HSPP(1), .VSPP(1),
    .ADDR_W(AW), .SCALE_LOG2(1), .RD_LAT(2)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .base_a(base_a1), .base_b(base_b1),
    .swap_req(swap_req1), .swap_ack(swap_ack1), .buf_sel(buf_sel1), .fb(fb1),
    .hsync(hs1), .vsync(vs1), .data_enable(de1), .red(r1), .green(g1), .blue(b1),
    .frame_start(fs1), .hdata(hd1), .vdata(vd1)
  );

  // Two-cycle memory: returns the address as data, junk when not strobed.
  logic [31:0] m0_p1, m1_p1;
  always @(posedge clk) begin
    m0_p1       <= fb0.rd_en ? 32'(fb0.rd_addr) : 32'h00FF_FFFF;
    fb0.rd_data <= m0_p1;
    m1_p1       <= fb1.rd_en ? 32'(fb1.rd_addr) : 32'h00FF_FFFF;
    fb1.rd_data <= m1_p1;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cur      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cur);
    end
  endtask

  task automatic adv();
    @(negedge clk);
    #1;
    cur++;
  endtask

  task automatic go_to(input int target);
    while (cur < target) adv();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cur = 0;
  endtask

  typedef struct {
    int   n;
    bit   en;
    int   a0;
    int   a1;
    bit   hs;
    bit   vs;
    bit   de;
    bit   fs;
    int   rgb;
  } vec_t;

  vec_t vecs[$];
  int   pulses;

  initial begin
    //            n    en  a0      a1 hs vs de fs rgb
    vecs.push_back('{  0, 1, 'h100, 0, 0, 0, 0, 0, 'h000000});
    vecs.push_back('{  1, 1, 'h101, 0, 0, 0, 0, 0, 'h000000});
    vecs.push_back('{  2, 1, 'h102, 1, 0, 0, 1, 1, 'h000100});
    vecs.push_back('{  3, 1, 'h103, 1, 0, 0, 1, 0, 'h000101});
    vecs.push_back('{  7, 1, 'h107, 3, 0, 0, 1, 0, 'h000105});
    vecs.push_back('{  8, 0, 0,     0, 0, 0, 1, 0, 'h000106});
    vecs.push_back('{ 10, 0, 0,     0, 0, 0, 0, 0, 'h000000});
    vecs.push_back('{ 12, 0, 0,     0, 1, 0, 0, 0, 'h000000});
    vecs.push_back('{ 13, 0, 0,     0, 1, 0, 0, 0, 'h000000});
    vecs.push_back('{ 14, 1, 'h108, 0, 0, 0, 0, 0, 'h000000});
    vecs.push_back('{ 16, 1, 'h10A, 1, 0, 0, 1, 0, 'h000108});
    vecs.push_back('{ 28, 1, 'h110, 4, 0, 0, 0, 0, 'h000000});
    vecs.push_back('{ 31, 1, 'h113, 5, 0, 0, 1, 0, 'h000111});
    vecs.push_back('{ 49, 1, 'h11F, 7, 0, 0, 1, 0, 'h00011D});
    vecs.push_back('{ 51, 0, 0,     0, 0, 0, 1, 0, 'h00011F});
    vecs.push_back('{ 56, 0, 0,     0, 0, 0, 0, 0, 'h000000});
    vecs.push_back('{ 58, 0, 0,     0, 0, 0, 0, 0, 'h000000});
    vecs.push_back('{ 71, 0, 0,     0, 0, 0, 0, 0, 'h000000});
    vecs.push_back('{ 72, 0, 0,     0, 0, 1, 0, 0, 'h000000});
    vecs.push_back('{ 82, 0, 0,     0, 1, 1, 0, 0, 'h000000});
    vecs.push_back('{ 85, 0, 0,     0, 0, 1, 0, 0, 'h000000});
    vecs.push_back('{ 86, 0, 0,     0, 0, 0, 0, 0, 'h000000});
    vecs.push_back('{ 97, 0, 0,     0, 1, 0, 0, 0, 'h000000});
    vecs.push_back('{ 98, 1, 'h100, 0, 0, 0, 0, 0, 'h000000});
    vecs.push_back('{100, 1, 'h102, 1, 0, 0, 1, 1, 'h000100});

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst hdata",    32'(hd0), 32'd0);
    check("rst vdata",    32'(vd0), 32'd0);
    check("rst buf_sel",  32'(buf_sel0), 32'd0);
    check("rst swap_ack", 32'(swap_ack0), 32'd0);
    check("rst rd_en",    32'(fb0.rd_en), 32'd0);
    check("rst rd_addr",  32'(fb0.rd_addr), 32'h100);
    check("rst hsync",    32'(hs0), 32'd0);
    check("rst vsync",    32'(vs0), 32'd0);
    check("rst de",       32'(de0), 32'd0);
    check("rst fs",       32'(fs0), 32'd0);
    check("rst rgb",      32'({r0, g0, b0}), 32'd0);

    // Frame 0 and start of frame 1
    release_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      go_to(vecs[i].n);
      check($sformatf("v%0d hdata", i), 32'(hd0), 32'((vecs[i].n % 98) % 14));
      check($sformatf("v%0d vdata", i), 32'(vd0), 32'((vecs[i].n % 98) / 14));
      check($sformatf("v%0d rd_en", i), 32'(fb0.rd_en), 32'(vecs[i].en));
      check($sformatf("v%0d rd_en s1", i), 32'(fb1.rd_en), 32'(vecs[i].en));
      if (vecs[i].en) begin
        check($sformatf("v%0d rd_addr", i), 32'(fb0.rd_addr), 32'(vecs[i].a0));
        check($sformatf("v%0d rd_addr s1", i), 32'(fb1.rd_addr), 32'(vecs[i].a1));
      end
      check($sformatf("v%0d hsync", i), 32'(hs0), 32'(vecs[i].hs));
      check($sformatf("v%0d vsync", i), 32'(vs0), 32'(vecs[i].vs));
      check($sformatf("v%0d de", i), 32'(de0), 32'(vecs[i].de));
      check($sformatf("v%0d fs", i), 32'(fs0), 32'(vecs[i].fs));
      check($sformatf("v%0d rgb", i), 32'({r0, g0, b0}), 32'(vecs[i].rgb));
      check($sformatf("v%0d buf_sel", i), 32'(buf_sel0), 32'd0);
    end

    // Mid-frame swap request takes effect only at the frame wrap
    go_to(110);
    swap_req0 = 1'b1;
    adv();
    swap_req0 = 1'b0;
    pulses = 0;
    while (cur < 198) begin
      adv();
      if (swap_ack0) pulses++;
      if (cur == 195) check("swap pre buf_sel", 32'(buf_sel0), 32'd0);
      if (cur == 196) begin
        check("swap buf_sel", 32'(buf_sel0), 32'd1);
        check("swap ack", 32'(swap_ack0), 32'd1);
        check("swap rd_addr", 32'(fb0.rd_addr), 32'h200);
      end
      if (cur == 197) check("swap ack drop", 32'(swap_ack0), 32'd0);
    end
    check("swap ack pulses", 32'(pulses), 32'd1);
    check("swap frame rgb", 32'({r0, g0, b0}), 32'h000200);
    check("swap frame fs", 32'(fs0), 32'd1);

    // Reset at (5,2) with a swap pending: pending request must be lost
    go_to(200);
    swap_req0 = 1'b1;
    adv();
    swap_req0 = 1'b0;
    go_to(229);
    check("pre-rst de", 32'(de0), 32'd1);
    check("pre-rst buf_sel", 32'(buf_sel0), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid-rst hsync", 32'(hs0), 32'd0);
    check("mid-rst de", 32'(de0), 32'd0);
    check("mid-rst buf_sel", 32'(buf_sel0), 32'd0);
    check("mid-rst hdata", 32'(hd0), 32'd0);
    check("mid-rst vdata", 32'(vd0), 32'd0);
    check("mid-rst rgb", 32'({r0, g0, b0}), 32'd0);
    check("mid-rst rd_en", 32'(fb0.rd_en), 32'd0);
    repeat (2) @(negedge clk);
    release_reset();
    check("post-rst hdata", 32'(hd0), 32'd0);
    check("post-rst vdata", 32'(vd0), 32'd0);
    adv();
    check("post-rst hdata+1", 32'(hd0), 32'd1);
    pulses = 0;
    while (cur < 98) begin
      adv();
      if (swap_ack0) pulses++;
    end
    check("post-rst no ack", 32'(pulses), 32'd0);
    check("post-rst buf_sel", 32'(buf_sel0), 32'd0);
    check("post-rst rd_addr", 32'(fb0.rd_addr), 32'h100);

    // Request raised exactly on the wrap cycle (13,6)
    go_to(195);
    check("late req hdata", 32'(hd0), 32'd13);
    check("late req vdata", 32'(vd0), 32'd6);
    swap_req0 = 1'b1;
    adv();
    swap_req0 = 1'b0;
    check("late swap buf_sel", 32'(buf_sel0), 32'd1);
    check("late swap ack", 32'(swap_ack0), 32'd1);
    check("late swap rd_addr", 32'(fb0.rd_addr), 32'h200);
    adv();
    check("late swap ack drop", 32'(swap_ack0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
